// File: rtl/dec_sel_sequencer.sv
// Scan sequencer driving the 4-bit select of binDec4to16: steps through the
// latched enable mask, holding each code for dwell_eff cycles.
module dec_sel_sequencer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        en_mask,
  output logic [3:0]         code,
  output logic               code_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e             state_q, state_d;
  logic [3:0]         code_q, code_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] rel_q, rel_d;   // dwell_eff - 1, reload value
  logic [15:0]        mask_q, mask_d;
  logic               cont_q, cont_d;

  // {found, index} of the lowest set bit
  function automatic logic [4:0] lowest(input logic [15:0] v);
    lowest = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lowest = {1'b1, 4'(i)};
  endfunction

  logic [4:0] first_in, first_lat, next_lat;
  assign first_in  = lowest(en_mask);
  assign first_lat = lowest(mask_q);
  assign next_lat  = lowest(mask_q & (16'hFFFE << code_q));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    case (state_q)
      IDLE: begin
        if (start && !stop && first_in[4]) begin
          state_d = SCAN;
          mask_d  = en_mask;
          cont_d  = mode_cont;
          rel_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          cnt_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          code_d  = first_in[3:0];
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        // stop wins over a coincident advance
        if (stop) begin
          state_d = IDLE;
          code_d  = '0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (next_lat[4]) begin
          code_d = next_lat[3:0];
          cnt_d  = rel_q;
        end else if (cont_q) begin
          code_d = first_lat[3:0];
          cnt_d  = rel_q;
          wrap_d = 1'b1;
        end else begin
          state_d = IDLE;
          code_d  = '0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      rel_q   <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  assign code       = code_q;
  assign code_valid = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Directed bench for dec_sel_sequencer; outputs sampled on the falling edge.
module tb_dec_sel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode_cont;
  logic [15:0] dwell;
  logic [15:0] en_mask;
  logic [3:0]  code;
  logic        code_valid, busy, done, wrap;

  int checks = 0;
  int errors = 0;

  dec_sel_sequencer #(.DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_cont(mode_cont), .dwell(dwell), .en_mask(en_mask),
    .code(code), .code_valid(code_valid), .busy(busy),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_code"}, int'(code), 0);
    chk({tag, "_vld"},  int'(code_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_start(input logic [15:0] m, input int dw, input logic c);
    @(negedge clk);
    en_mask = m; dwell = 16'(dw); mode_cont = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // walk the enabled codes in ascending order, dw cycles each
  task automatic run_scan(input logic [15:0] m, input int dw);
    for (int k = 0; k < 16; k++)
      if (m[k])
        for (int d = 0; d < dw; d++) begin
          @(negedge clk);
          chk("scan_code",  int'(code), k);
          chk("scan_vld",   int'(code_valid), 1);
          chk("scan_busy",  int'(busy), 1);
          chk("scan_pulse", int'({done, wrap}), 0);
        end
  endtask

  task automatic expect_done();
    @(negedge clk);
    chk_idle("done_cyc");
    chk("done_pulse", int'(done), 1);
    chk("done_nowrap", int'(wrap), 0);
  endtask

  int cont_code [10] = '{0, 0, 2, 2, 0, 0, 2, 2, 0, 0};
  int cont_wrap [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    dwell = 16'd1; en_mask = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_pulse", int'({done, wrap}), 0);
    @(negedge clk) rst_n = 1'b1;

    // full mask, dwell 1, single pass
    do_start(16'hFFFF, 1, 1'b0);
    run_scan(16'hFFFF, 1);
    expect_done();
    @(negedge clk);
    chk("done_width", int'(done), 0);

    // sparse mask, dwell 3; restart accepted in the done cycle with dwell 0
    do_start(16'h8421, 3, 1'b0);
    run_scan(16'h8421, 3);
    expect_done();
    en_mask = 16'h8421; dwell = 16'd0; mode_cont = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    run_scan(16'h8421, 1);
    expect_done();

    // continuous two-code scan, then stop
    do_start(16'h0005, 2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("cont_code", int'(code), cont_code[c]);
      chk("cont_wrap", int'(wrap), cont_wrap[c]);
      chk("cont_nodone", int'(done), 0);
      chk("cont_busy", int'(busy), 1);
    end
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk_idle("cont_stop");
    chk("cont_stop_pulse", int'({done, wrap}), 0);

    // single enabled bit, continuous: wrap every cycle at dwell 1
    do_start(16'h0010, 1, 1'b1);
    @(negedge clk);
    chk("one_code0", int'(code), 4);
    chk("one_wrap0", int'(wrap), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("one_code", int'(code), 4);
      chk("one_wrap", int'(wrap), 1);
    end
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk_idle("one_stop");

    // stop in the last dwell cycle of code 5 beats the advance
    do_start(16'h8421, 3, 1'b0);
    run_scan(16'h0021, 3);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk_idle("stop_adv");
    chk("stop_nodone", int'(done), 0);
    @(negedge clk);
    chk("stop_nodone2", int'(done), 0);

    // start with empty mask is ignored
    do_start(16'h0000, 1, 1'b0);
    @(negedge clk);
    chk_idle("empty_start");
    chk("empty_pulse", int'({done, wrap}), 0);

    // input changes and start while busy have no effect
    do_start(16'h8421, 2, 1'b0);
    en_mask = 16'h0001; dwell = 16'd5; mode_cont = 1'b1; start = 1'b1;
    run_scan(16'h0021, 2);
    start = 1'b0;
    run_scan(16'h8400, 2);
    expect_done();

    // asynchronous reset mid-scan clears outputs before the next edge
    do_start(16'h0080, 10, 1'b0);
    @(negedge clk);
    chk("pre_rst_code", int'(code), 7);
    chk("pre_rst_vld", int'(code_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("post_rst");
      chk("post_rst_pulse", int'({done, wrap}), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_sel_sequencer.md
# dec_sel_sequencer

Registered scan sequencer that produces the 4-bit select code consumed by the 4-to-16 binary decoder (`binDec4to16`), stepping through a programmable subset of the 16 outputs. It holds each code for a programmable number of cycles, in single-pass or continuous mode, with start/stop control and status pulses. It sits directly upstream of the decoder and drives its `in` port from a register, so the decoder's one-hot output is glitch-free and cycle-aligned with `code_valid`.

## Interface
- DWELL_W, 16, width of dwell count (cycles per code)
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin scan (sampled in IDLE only)
- stop  input  1  abort scan (sampled in SCAN only)
- mode_cont  input  1  1 = continuous wrap, 0 = single pass; latched at start
- dwell  input  DWELL_W  cycles each code is held; 0 treated as 1; latched at start
- en_mask  input  16  bit k = 1 includes code k in scan; latched at start
- code  output  4  select code to decoder `in`
- code_valid  output  1  code is an active scan value
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse on normal single-pass completion
- wrap  output  1  one-cycle pulse when continuous scan restarts at lowest enabled code

## Operation
- States: IDLE, SCAN. All outputs registered.
- Reset (async assert, any state): state IDLE; code=0, code_valid=0, busy=0, done=0, wrap=0; dwell counter and latched mask/mode cleared. Deassertion is synchronous to clk by the instantiating level.
- IDLE: code=0, code_valid=0, busy=0. On a cycle with start=1, stop=0, en_mask!=0: latch mask, mode_cont, dwell_eff=max(dwell,1); at that edge code <= lowest set bit index of en_mask, code_valid<=1, busy<=1, counter<=dwell_eff-1, go SCAN.
- start with en_mask==0: ignored, stay IDLE, no pulses. start and stop together in IDLE: stay IDLE.
- SCAN, counter>0: decrement; code held.
- SCAN, counter==0 (advance): next = lowest enabled index strictly above code.
  - next exists: code<=next, counter<=dwell_eff-1.
  - none, mode 0: go IDLE, code<=0, code_valid<=0, busy<=0, done<=1 for one cycle.
  - none, mode 1: code<=lowest enabled index, counter reload, wrap<=1 for one cycle (coincident with first cycle of re-presented code).
- stop=1 in SCAN: at next edge go IDLE, code<=0, code_valid<=0, busy<=0; no done, no wrap. stop has priority over a coincident advance.
- start while in SCAN: ignored. Changes to en_mask/dwell/mode_cont during SCAN: no effect until next start.
- Single enabled bit, continuous mode: code unchanged, wrap pulses every dwell_eff cycles.
- Code arithmetic: 4-bit, never exceeds 15; search is a priority find over latched mask bits above current index.

## Timing
- start sampled at edge E: code/code_valid/busy valid from E+1.
- Each code held exactly dwell_eff cycles with code_valid=1.
- Single pass with n enabled codes: busy high n*dwell_eff cycles; done high in the first IDLE cycle, i.e. E+1+n*dwell_eff; a new start is accepted in that same cycle.
- stop sampled at edge S: code_valid=0 from S+1.
- done and wrap never high simultaneously; each exactly one cycle wide.
- Decoder output follows code combinationally; no extra latency added here.

## Test plan
- Reset mid-scan (rst_n low with code=7, code_valid=1) -> all outputs 0 immediately, before the next clk edge; after release, stays IDLE until start.
- en_mask=16'hFFFF, dwell=1, mode 0, start at edge 0 -> code=k during cycle 1+k for k=0..15, done=1 and busy=0 in cycle 17.
- en_mask=16'h8421, dwell=3, mode 0 -> codes 0,5,10,15, each for 3 cycles, cycles 1-12; done in cycle 13; dwell=0 run gives 1 cycle per code.
- en_mask=16'h0005, dwell=2, mode 1 -> 0,0,2,2,0,0,... with wrap=1 in cycle 5, 9, ...; no done.
- stop asserted in the last cycle of code 5 (counter==0) -> next cycle code=0, code_valid=0, no done; start with en_mask=0 -> stays IDLE.
- en_mask changed to 16'h0001 mid-scan and start pulsed while busy -> scan continues with original mask and timing.
